sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock FIFO with independent write and read widths (integer power-of-two ratio), selectable standard or first-word-fall-through (FWFT) read mode, and occupancy/free-space counters on both sides. It sits between a producer and a consumer in the same clock domain. It also serves as a width converter, e.g. 16-bit to 8-bit.

## Interface
- INPUT_WIDTH, 16, write data width in bits.
- OUTPUT_WIDTH, 16, read data width in bits. max(INPUT_WIDTH, OUTPUT_WIDTH)/min(...) is a power of two.
- WR_DEPTH, 16, capacity in input words (power of two). If INPUT_WIDTH < OUTPUT_WIDTH, WR_DEPTH = (OUTPUT_WIDTH/INPUT_WIDTH)*RD_DEPTH.
- RD_DEPTH, 16, capacity in output words (power of two). If INPUT_WIDTH > OUTPUT_WIDTH, RD_DEPTH = (INPUT_WIDTH/OUTPUT_WIDTH)*WR_DEPTH.
- MODE, "FWFT", "FWFT" or "STANDARD".
- DIRECTION, "LSB", "LSB" or "MSB": the end of the wide word that is filled or emptied first.
- sys_clk  in  1  clock; all logic is rising-edge.
- sys_rst  in  1  reset; asynchronous, active-low.
- wr_en  in  1  write request.
- din  in  INPUT_WIDTH  write data.
- rd_en  in  1  read request / acknowledge.
- valid  out  1  dout holds a valid word.
- dout  out  OUTPUT_WIDTH  read data.
- full  out  1  fewer than one input word of space.
- empty  out  1  fewer than one complete output word stored.
- wr_data_count  out  $clog2(WR_DEPTH)+1  stored data in input words.
- rd_data_count  out  $clog2(RD_DEPTH)+1  stored data in output words.
- wr_data_space  out  $clog2(WR_DEPTH)+1  WR_DEPTH − wr_data_count.
- rd_data_space  out  $clog2(RD_DEPTH)+1  RD_DEPTH − rd_data_count.

## Operation
- Storage is in units of the narrow width W = min(INPUT_WIDTH, OUTPUT_WIDTH), with N = max(WR_DEPTH, RD_DEPTH) entries.
  - Input ratio Ri = INPUT_WIDTH/W; output ratio Ro = OUTPUT_WIDTH/W.
  - The occupancy counter U (0..N) is in narrow units.
- wr_data_count = U/Ri and rd_data_count = U/Ro, both floor division.
- full = (wr_data_space == 0); empty = (rd_data_count == 0).
- A partial wide output word is not readable.
- An accepted write (wr_en & ~full) stores Ri narrow slices.
  - DIRECTION "LSB": slice din[W-1:0] comes first in the stream.
  - DIRECTION "MSB": the top slice comes first.
- An accepted read assembles Ro consecutive slices. The first slice goes to the low bits for "LSB" and to the high bits for "MSB".
- full is evaluated on the current state only. A write while full is dropped even if a read occurs in the same cycle.
- A read while empty is dropped.
- Simultaneous accepted read and write: U ← U + Ri − Ro.
- Pointers are in narrow units and wrap modulo N. Counters never overflow or underflow.
- STANDARD mode:
  - Accepted read = rd_en & ~empty.
  - dout and valid are registered. valid pulses for one cycle per accepted read.
  - dout holds its last value otherwise.
- FWFT mode:
  - dout continuously shows the head word while not empty; valid = ~empty.
  - Accepted read = rd_en & valid. The next word (or valid=0) appears the following cycle.

## Timing
- Reset values: valid=0, dout=0, empty=1, full=0, all counts 0, wr_data_space=WR_DEPTH, rd_data_space=RD_DEPTH, pointers 0.
- Reset asserted mid-operation discards all contents immediately.
- Flags and counts are registered and reflect all accepted operations up to and including the last rising edge.
- FWFT: a write at edge k deasserts empty and asserts valid with the data after edge k.
- STANDARD: read latency is 1 cycle. An rd_en accepted at edge k gives valid=1 and dout=word after edge k, for that cycle only.
- The last accepted write asserts full after the same edge. The last accepted read asserts empty after the same edge.

## Structure
- A shared package holds the MODE/DIRECTION string constants and the derived-width helpers (clog2, ratio).
- One sub-module, fifo_ram: a N×W register array with one write port and one read port. Multi-slice access is handled in sync_fifo through pointer offsets.

## Test plan
- Reset: assert sys_rst=0 mid-stream → empty=1, full=0, valid=0, counts 0, spaces 16; the next read sees no old data.
- Fill, default params: write 18 words, din starting 0x0123, each byte +1 per write (0x0123, 0x0224, …) → first 16 accepted, full=1, wr_data_count=16, words 17–18 dropped.
- FWFT drain: after the fill, rd_en held → dout = 0x0123, 0x0224, … 0x1032 in order, one per cycle. valid=0 and empty=1 after the 16th read, and no further data follows.
- STANDARD mode: single rd_en pulse → valid high exactly one cycle later with dout=0x0123; rd_data_count decrements by 1.
- Width conversion, INPUT 16 / OUTPUT 8 / WR 16 / RD 32:
  - LSB: write 0x0123 → rd_data_count=2; reads return 0x23 then 0x01.
  - MSB: reads return 0x01 then 0x23.
  - Reverse direction (8→16, LSB): write 0x23, 0x01 → one read returns 0x0123; after only one write, empty stays 1.
- Simultaneous read/write at count 8 for 10 cycles → counts stay 8 and ordering is preserved. Write while full plus read → only the read is accepted, count becomes 15.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
//   Shared constants and elaboration-time helpers for sync_fifo.
//   - MODE_* / DIR_* : legal values of the MODE and DIRECTION string parameters.
//   - clog2_f        : ceil(log2(value)), 0 for value <= 1.
//   - ratio_f        : max(a,b)/min(a,b), the wide-to-narrow width ratio.
//   - min_f / max_f  : integer min/max used to derive storage geometry.
package sync_fifo_pkg;

  localparam string MODE_FWFT     = "FWFT";
  localparam string MODE_STANDARD = "STANDARD";
  localparam string DIR_LSB       = "LSB";
  localparam string DIR_MSB       = "MSB";

  function automatic int clog2_f(input int value);
    int result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int min_f(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int ratio_f(input int a, input int b);
    return max_f(a, b) / min_f(a, b);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram
//   DEPTH x W register array used as the FIFO storage. One write port and one
//   read port, each WR_SLICES / RD_SLICES narrow entries wide; the caller
//   supplies one address per slice so it controls wrap-around.
//   Ports:
//     clk      in  rising-edge clock
//     wr_en    in  write all WR_SLICES slices this cycle
//     wr_addr  in  per-slice write address
//     wr_data  in  per-slice write data
//     rd_addr  in  per-slice read address
//     rd_data  out per-slice read data (combinational from the array)
module fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int W         = 8,
  parameter int DEPTH     = 16,
  parameter int WR_SLICES = 1,
  parameter int RD_SLICES = 1,
  localparam int AW       = clog2_f(DEPTH)
) (
  input  logic                             clk,
  input  logic                             wr_en,
  input  logic [WR_SLICES-1:0][AW-1:0]     wr_addr,
  input  logic [WR_SLICES-1:0][W-1:0]      wr_data,
  input  logic [RD_SLICES-1:0][AW-1:0]     rd_addr,
  output logic [RD_SLICES-1:0][W-1:0]      rd_data
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  // No reset: contents are only ever observed through the FIFO pointers,
  // which are reset, so stale entries are never visible.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int j = 0; j < WR_SLICES; j++) begin
        mem_d[wr_addr[j]] = wr_data[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rd_data = '0;
    for (int j = 0; j < RD_SLICES; j++) begin
      rd_data[j] = mem_q[rd_addr[j]];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with independent write/read widths (power-of-two ratio),
//   STANDARD or first-word-fall-through read mode, and occupancy / free-space
//   counters on both sides. Storage is in narrow units W = min(widths).
//   Ports:
//     sys_clk, sys_rst  clock (rising edge), asynchronous active-low reset
//     wr_en, din        write request and data (INPUT_WIDTH)
//     rd_en             read request (STANDARD) / acknowledge (FWFT)
//     valid, dout       output word and its qualifier (OUTPUT_WIDTH)
//     full, empty       no room for an input word / no complete output word
//     wr_data_count     stored data in input words,  wr_data_space = free
//     rd_data_count     stored data in output words, rd_data_space = free
//
//   Handshake: a write is accepted on a rising edge where wr_en & ~full; a
//   read is accepted on a rising edge where rd_en & ~empty (in FWFT mode
//   valid == ~empty, so this equals rd_en & valid). Requests that are not
//   accepted are dropped, never queued. full/empty are the registered flags,
//   so a read in the same cycle never frees room for a write.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int    INPUT_WIDTH  = 16,
  parameter int    OUTPUT_WIDTH = 16,
  parameter int    WR_DEPTH     = 16,
  parameter int    RD_DEPTH     = 16,
  parameter string MODE         = MODE_FWFT,
  parameter string DIRECTION    = DIR_LSB
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        wr_en,
  input  logic [INPUT_WIDTH-1:0]      din,
  input  logic                        rd_en,
  output logic                        valid,
  output logic [OUTPUT_WIDTH-1:0]     dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(WR_DEPTH):0]   wr_data_count,
  output logic [$clog2(RD_DEPTH):0]   rd_data_count,
  output logic [$clog2(WR_DEPTH):0]   wr_data_space,
  output logic [$clog2(RD_DEPTH):0]   rd_data_space
);

  localparam int W       = min_f(INPUT_WIDTH, OUTPUT_WIDTH);
  localparam int N       = max_f(WR_DEPTH, RD_DEPTH);
  localparam int RI      = ratio_f(INPUT_WIDTH, W);
  localparam int RO      = ratio_f(OUTPUT_WIDTH, W);
  localparam int LRI     = clog2_f(RI);
  localparam int LRO     = clog2_f(RO);
  localparam int AW      = clog2_f(N);
  localparam int CW      = AW + 1;
  localparam int WCW     = clog2_f(WR_DEPTH) + 1;
  localparam int RCW     = clog2_f(RD_DEPTH) + 1;
  localparam bit IS_FWFT = (MODE != MODE_STANDARD);
  localparam bit IS_LSB  = (DIRECTION != DIR_MSB);

  logic [CW-1:0]  used_q, used_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic           full_q, full_d;
  logic           empty_q, empty_d;
  logic [WCW-1:0] wr_cnt_q, wr_cnt_d;
  logic [WCW-1:0] wr_space_q, wr_space_d;
  logic [RCW-1:0] rd_cnt_q, rd_cnt_d;
  logic [RCW-1:0] rd_space_q, rd_space_d;
  logic           valid_q, valid_d;
  logic [OUTPUT_WIDTH-1:0] dout_q, dout_d;

  logic wr_acc;
  logic rd_acc;

  logic [RI-1:0][AW-1:0] wr_addr;
  logic [RI-1:0][W-1:0]  wr_slices;
  logic [RO-1:0][AW-1:0] rd_addr;
  logic [RO-1:0][W-1:0]  rd_slices;
  logic [RO-1:0][W-1:0]  head_word;

  assign wr_acc = wr_en & ~full_q;
  assign rd_acc = rd_en & ~empty_q;

  // Slice j of the stream goes to wr_ptr+j; DIRECTION picks which end of the
  // wide input word is slice 0. Addresses wrap naturally at N (power of two).
  always_comb begin
    wr_addr   = '0;
    wr_slices = '0;
    for (int j = 0; j < RI; j++) begin
      wr_addr[j] = wr_ptr_q + AW'(j);
      if (IS_LSB) wr_slices[j] = din[j*W +: W];
      else        wr_slices[j] = din[(RI-1-j)*W +: W];
    end
  end

  always_comb begin
    rd_addr   = '0;
    head_word = '0;
    for (int j = 0; j < RO; j++) begin
      rd_addr[j] = rd_ptr_q + AW'(j);
      if (IS_LSB) head_word[j]        = rd_slices[j];
      else        head_word[RO-1-j]   = rd_slices[j];
    end
  end

  fifo_ram #(
    .W         (W),
    .DEPTH     (N),
    .WR_SLICES (RI),
    .RD_SLICES (RO)
  ) u_ram (
    .clk     (sys_clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_addr),
    .wr_data (wr_slices),
    .rd_addr (rd_addr),
    .rd_data (rd_slices)
  );

  // Occupancy in narrow units; both sides' counts and flags derive from the
  // next value so they are registered yet reflect the edge just taken.
  always_comb begin
    used_d = used_q;
    if (wr_acc) used_d = used_d + CW'(RI);
    if (rd_acc) used_d = used_d - CW'(RO);

    wr_ptr_d = wr_acc ? (wr_ptr_q + AW'(RI)) : wr_ptr_q;
    rd_ptr_d = rd_acc ? (rd_ptr_q + AW'(RO)) : rd_ptr_q;

    wr_cnt_d   = WCW'(used_d >> LRI);
    rd_cnt_d   = RCW'(used_d >> LRO);
    wr_space_d = WCW'(WR_DEPTH) - wr_cnt_d;
    rd_space_d = RCW'(RD_DEPTH) - rd_cnt_d;
    full_d     = (wr_space_d == '0);
    empty_d    = (rd_cnt_d == '0);

    // Output register is only meaningful in STANDARD mode; in FWFT it stays 0.
    valid_d = rd_acc && !IS_FWFT;
    dout_d  = (rd_acc && !IS_FWFT) ? OUTPUT_WIDTH'(head_word) : dout_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      used_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      wr_space_q <= WCW'(WR_DEPTH);
      rd_space_q <= RCW'(RD_DEPTH);
      valid_q    <= 1'b0;
      dout_q     <= '0;
    end else begin
      used_q     <= used_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_space_q <= wr_space_d;
      rd_space_q <= rd_space_d;
      valid_q    <= valid_d;
      dout_q     <= dout_d;
    end
  end

  // FWFT shows the head word straight from storage; it is forced to 0 while
  // empty so no stale entry is ever presented.
  assign valid = IS_FWFT ? ~empty_q : valid_q;
  assign dout  = IS_FWFT ? (empty_q ? '0 : OUTPUT_WIDTH'(head_word)) : dout_q;

  assign full          = full_q;
  assign empty         = empty_q;
  assign wr_data_count = wr_cnt_q;
  assign rd_data_count = rd_cnt_q;
  assign wr_data_space = wr_space_q;
  assign rd_data_space = rd_space_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo
//   Self-checking bench for sync_fifo. Five instances share clock and reset:
//   FWFT 16/16, STANDARD 16/16, 16->8 LSB, 16->8 MSB, 8->16 LSB.
//   Inputs change on the falling edge; outputs are sampled there too.
module tb_sync_fifo;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT signals ----------------
  logic        f_wr, f_rd, f_valid, f_full, f_empty;
  logic [15:0] f_din, f_dout;
  logic [4:0]  f_wr_cnt, f_rd_cnt, f_wr_sp, f_rd_sp;

  logic        s_wr, s_rd, s_valid, s_full, s_empty;
  logic [15:0] s_din, s_dout;
  logic [4:0]  s_wr_cnt, s_rd_cnt, s_wr_sp, s_rd_sp;

  logic        nl_wr, nl_rd, nl_valid, nl_full, nl_empty;
  logic [15:0] nl_din;
  logic [7:0]  nl_dout;
  logic [4:0]  nl_wr_cnt, nl_wr_sp;
  logic [5:0]  nl_rd_cnt, nl_rd_sp;

  logic        nm_wr, nm_rd, nm_valid, nm_full, nm_empty;
  logic [15:0] nm_din;
  logic [7:0]  nm_dout;
  logic [4:0]  nm_wr_cnt, nm_wr_sp;
  logic [5:0]  nm_rd_cnt, nm_rd_sp;

  logic        wl_wr, wl_rd, wl_valid, wl_full, wl_empty;
  logic [7:0]  wl_din;
  logic [15:0] wl_dout;
  logic [5:0]  wl_wr_cnt, wl_wr_sp;
  logic [4:0]  wl_rd_cnt, wl_rd_sp;

  sync_fifo u_fwft (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(f_wr), .din(f_din), .rd_en(f_rd),
    .valid(f_valid), .dout(f_dout), .full(f_full), .empty(f_empty),
    .wr_data_count(f_wr_cnt), .rd_data_count(f_rd_cnt),
    .wr_data_space(f_wr_sp), .rd_data_space(f_rd_sp)
  );

  sync_fifo #(.MODE("STANDARD")) u_std (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(s_wr), .din(s_din), .rd_en(s_rd),
    .valid(s_valid), .dout(s_dout), .full(s_full), .empty(s_empty),
    .wr_data_count(s_wr_cnt), .rd_data_count(s_rd_cnt),
    .wr_data_space(s_wr_sp), .rd_data_space(s_rd_sp)
  );

  sync_fifo #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(8), .WR_DEPTH(16), .RD_DEPTH(32),
              .DIRECTION("LSB")) u_nar_lsb (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(nl_wr), .din(nl_din), .rd_en(nl_rd),
    .valid(nl_valid), .dout(nl_dout), .full(nl_full), .empty(nl_empty),
    .wr_data_count(nl_wr_cnt), .rd_data_count(nl_rd_cnt),
    .wr_data_space(nl_wr_sp), .rd_data_space(nl_rd_sp)
  );

  sync_fifo #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(8), .WR_DEPTH(16), .RD_DEPTH(32),
              .DIRECTION("MSB")) u_nar_msb (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(nm_wr), .din(nm_din), .rd_en(nm_rd),
    .valid(nm_valid), .dout(nm_dout), .full(nm_full), .empty(nm_empty),
    .wr_data_count(nm_wr_cnt), .rd_data_count(nm_rd_cnt),
    .wr_data_space(nm_wr_sp), .rd_data_space(nm_rd_sp)
  );

  sync_fifo #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(16), .WR_DEPTH(32), .RD_DEPTH(16),
              .DIRECTION("LSB")) u_wide_lsb (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_en(wl_wr), .din(wl_din), .rd_en(wl_rd),
    .valid(wl_valid), .dout(wl_dout), .full(wl_full), .empty(wl_empty),
    .wr_data_count(wl_wr_cnt), .rd_data_count(wl_rd_cnt),
    .wr_data_space(wl_wr_sp), .rd_data_space(wl_rd_sp)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drain_f(input int max_cyc, input int exp_cyc, input string tag);
    int cyc = 0;
    f_rd = 1'b1;
    while (exp_q.size() > 0 && cyc < max_cyc) begin
      if (f_valid) check_eq(tag, f_dout, exp_q.pop_front());
      @(negedge sys_clk);
      cyc++;
    end
    f_rd = 1'b0;
    check_eq({tag, "_left"}, exp_q.size(), 0);
    check_eq({tag, "_cycles"}, cyc, exp_cyc);
  endtask

  task automatic write_n(input bit msb, input logic [15:0] data);
    if (msb) begin nm_wr = 1'b1; nm_din = data; end
    else     begin nl_wr = 1'b1; nl_din = data; end
    if (msb) begin exp_q.push_back({8'h00, data[15:8]}); exp_q.push_back({8'h00, data[7:0]}); end
    else     begin exp_q.push_back({8'h00, data[7:0]});  exp_q.push_back({8'h00, data[15:8]}); end
    @(negedge sys_clk);
    nm_wr = 1'b0;
    nl_wr = 1'b0;
  endtask

  task automatic drain_n(input bit msb, input int max_cyc, input int exp_cyc);
    int cyc = 0;
    string tag;
    tag = msb ? "msb_dout" : "lsb_dout";
    if (msb) nm_rd = 1'b1; else nl_rd = 1'b1;
    while (exp_q.size() > 0 && cyc < max_cyc) begin
      if (msb ? nm_valid : nl_valid)
        check_eq(tag, {24'h0, (msb ? nm_dout : nl_dout)}, {16'h0, exp_q.pop_front()});
      @(negedge sys_clk);
      cyc++;
    end
    nm_rd = 1'b0;
    nl_rd = 1'b0;
    check_eq("narrow_left", exp_q.size(), 0);
    check_eq("narrow_cycles", cyc, exp_cyc);
    check_eq("narrow_empty", msb ? nm_empty : nl_empty, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] last;
    int cyc;
    f_wr = 0; f_rd = 0; f_din = '0;
    s_wr = 0; s_rd = 0; s_din = '0;
    nl_wr = 0; nl_rd = 0; nl_din = '0;
    nm_wr = 0; nm_rd = 0; nm_din = '0;
    wl_wr = 0; wl_rd = 0; wl_din = '0;

    repeat (3) @(negedge sys_clk);
    check_eq("rst_empty", f_empty, 1);
    check_eq("rst_full", f_full, 0);
    check_eq("rst_valid", f_valid, 0);
    check_eq("rst_dout", f_dout, 0);
    check_eq("rst_wr_cnt", f_wr_cnt, 0);
    check_eq("rst_rd_cnt", f_rd_cnt, 0);
    check_eq("rst_wr_sp", f_wr_sp, 16);
    check_eq("rst_rd_sp", f_rd_sp, 16);
    check_eq("rst_std_valid", s_valid, 0);
    check_eq("rst_std_dout", s_dout, 0);
    check_eq("rst_nar_rd_sp", nl_rd_sp, 32);
    check_eq("rst_wide_wr_sp", wl_wr_sp, 32);
    sys_rst = 1'b1;
    @(negedge sys_clk);

    // Fill with 18 words; only the first 16 fit.
    for (int i = 0; i < 18; i++) begin
      f_wr = 1'b1;
      f_din = 16'h0123 + 16'(i) * 16'h0101;
      if (exp_q.size() < 16) exp_q.push_back(f_din);
      @(negedge sys_clk);
    end
    f_wr = 1'b0;
    check_eq("fill_full", f_full, 1);
    check_eq("fill_wr_cnt", f_wr_cnt, 16);
    check_eq("fill_wr_sp", f_wr_sp, 0);
    check_eq("fill_rd_cnt", f_rd_cnt, 16);
    check_eq("fill_valid", f_valid, 1);

    drain_f(40, 16, "fwft_drain");
    check_eq("drain_valid", f_valid, 0);
    check_eq("drain_empty", f_empty, 1);
    check_eq("drain_wr_sp", f_wr_sp, 16);
    f_rd = 1'b1;
    repeat (3) @(negedge sys_clk);
    f_rd = 1'b0;
    check_eq("underflow_valid", f_valid, 0);
    check_eq("underflow_rd_cnt", f_rd_cnt, 0);
    check_eq("underflow_rd_sp", f_rd_sp, 16);

    // Concurrent read/write at occupancy 8.
    for (int i = 0; i < 8; i++) begin
      f_wr = 1'b1;
      f_din = 16'($urandom_range(0, 65535));
      exp_q.push_back(f_din);
      @(negedge sys_clk);
    end
    f_wr = 1'b0;
    check_eq("rw_pre_cnt", f_wr_cnt, 8);
    for (int i = 0; i < 10; i++) begin
      f_wr = 1'b1;
      f_rd = 1'b1;
      f_din = 16'($urandom_range(0, 65535));
      check_eq("rw_dout", f_dout, exp_q.pop_front());
      exp_q.push_back(f_din);
      @(negedge sys_clk);
      check_eq("rw_count", f_wr_cnt, exp_q.size());
    end
    f_wr = 1'b0;
    f_rd = 1'b0;

    // Top up to full, then write+read together: only the read is taken.
    for (int i = 0; i < 8; i++) begin
      f_wr = 1'b1;
      f_din = 16'($urandom_range(0, 65535));
      exp_q.push_back(f_din);
      @(negedge sys_clk);
    end
    check_eq("refill_full", f_full, 1);
    f_wr = 1'b1;
    f_rd = 1'b1;
    f_din = 16'hDEAD;
    check_eq("full_rw_dout", f_dout, exp_q.pop_front());
    @(negedge sys_clk);
    f_wr = 1'b0;
    f_rd = 1'b0;
    check_eq("full_rw_cnt", f_wr_cnt, 15);
    check_eq("full_rw_full", f_full, 0);
    drain_f(40, 15, "full_rw_drain");

    // Reset asserted mid-stream takes effect without a clock edge.
    for (int i = 0; i < 5; i++) begin
      f_wr = 1'b1;
      f_din = 16'($urandom_range(0, 65535));
      @(negedge sys_clk);
    end
    sys_rst = 1'b0;
    #1;
    f_wr = 1'b0;
    check_eq("mid_rst_empty", f_empty, 1);
    check_eq("mid_rst_full", f_full, 0);
    check_eq("mid_rst_valid", f_valid, 0);
    check_eq("mid_rst_wr_cnt", f_wr_cnt, 0);
    check_eq("mid_rst_rd_cnt", f_rd_cnt, 0);
    check_eq("mid_rst_wr_sp", f_wr_sp, 16);
    check_eq("mid_rst_rd_sp", f_rd_sp, 16);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    f_rd = 1'b1;
    @(negedge sys_clk);
    f_rd = 1'b0;
    check_eq("post_rst_valid", f_valid, 0);
    check_eq("post_rst_rd_cnt", f_rd_cnt, 0);

    // STANDARD mode: one-cycle read latency, single-cycle valid pulse.
    for (int i = 0; i < 3; i++) begin
      s_wr = 1'b1;
      s_din = 16'h0123 + 16'(i) * 16'h0101;
      exp_q.push_back(s_din);
      @(negedge sys_clk);
    end
    s_wr = 1'b0;
    check_eq("std_rd_cnt3", s_rd_cnt, 3);
    check_eq("std_empty0", s_empty, 0);
    check_eq("std_valid_idle", s_valid, 0);
    s_rd = 1'b1;
    @(negedge sys_clk);
    s_rd = 1'b0;
    last = exp_q.pop_front();
    check_eq("std_valid", s_valid, 1);
    check_eq("std_dout", s_dout, last);
    check_eq("std_rd_cnt2", s_rd_cnt, 2);
    @(negedge sys_clk);
    check_eq("std_valid_pulse", s_valid, 0);
    check_eq("std_dout_hold", s_dout, last);
    s_rd = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 10) begin
      @(negedge sys_clk);
      cyc++;
      if (s_valid) check_eq("std_drain", s_dout, exp_q.pop_front());
    end
    check_eq("std_drain_cycles", cyc, 2);
    @(negedge sys_clk);
    s_rd = 1'b0;
    check_eq("std_empty_read", s_valid, 0);
    check_eq("std_empty", s_empty, 1);

    // 16 -> 8 width conversion, both directions.
    for (int m = 0; m < 2; m++) begin
      write_n(m[0], 16'h0123);
      check_eq("nar_rd_cnt", m[0] ? nm_rd_cnt : nl_rd_cnt, 2);
      check_eq("nar_wr_cnt", m[0] ? nm_wr_cnt : nl_wr_cnt, 1);
      check_eq("nar_rd_sp", m[0] ? nm_rd_sp : nl_rd_sp, 30);
      check_eq("nar_wr_sp", m[0] ? nm_wr_sp : nl_wr_sp, 15);
      write_n(m[0], 16'($urandom_range(0, 65535)));
      drain_n(m[0], 10, 4);
    end

    // 8 -> 16: a half word is not readable.
    wl_wr = 1'b1;
    wl_din = 8'h23;
    @(negedge sys_clk);
    wl_wr = 1'b0;
    check_eq("wide_half_empty", wl_empty, 1);
    check_eq("wide_half_valid", wl_valid, 0);
    check_eq("wide_half_wr_cnt", wl_wr_cnt, 1);
    check_eq("wide_half_rd_cnt", wl_rd_cnt, 0);
    wl_wr = 1'b1;
    wl_din = 8'h01;
    exp_q.push_back(16'h0123);
    @(negedge sys_clk);
    wl_wr = 1'b0;
    check_eq("wide_empty", wl_empty, 0);
    check_eq("wide_rd_cnt", wl_rd_cnt, 1);
    check_eq("wide_valid", wl_valid, 1);
    check_eq("wide_dout", wl_dout, exp_q.pop_front());
    wl_rd = 1'b1;
    @(negedge sys_clk);
    wl_rd = 1'b0;
    check_eq("wide_after_empty", wl_empty, 1);
    check_eq("wide_after_wr_cnt", wl_wr_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
